// File: rtl/pc_unit.sv
// ============================================================================
//  Module   : pc_unit
//  Brief    : Fetch-stage program counter with stall, branch/jump redirect,
//             trap entry/return, target alignment check and fetch qualifier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned INC          = 4,
  parameter int unsigned ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exception,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic [WIDTH-1:0] epc,
  output logic             fetch_valid,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] c_resetPc = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] c_excPc   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] c_incVal  = WIDTH'(INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pcState_t;

  pcState_t         r_state;
  pcState_t         w_nextState;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_fetchValid;
  logic             r_misalign;
  logic [WIDTH-1:0] w_nextPc;
  logic [WIDTH-1:0] w_nextEpc;
  logic [WIDTH-1:0] w_pcPlusInc;
  logic             w_misalignHit;
  logic             w_jumpMis;
  logic             w_branchMis;

  assign w_pcPlusInc = r_pc + c_incVal;

  generate
    if (ALIGN_BITS > 0) begin : g_alignChk
      assign w_jumpMis   = |jump_target[ALIGN_BITS-1:0];
      assign w_branchMis = |branch_target[ALIGN_BITS-1:0];
    end else begin : g_noAlignChk
      assign w_jumpMis   = 1'b0;
      assign w_branchMis = 1'b0;
    end
  endgenerate

  always_comb begin
    w_nextState   = r_state;
    w_nextPc      = r_pc;
    w_nextEpc     = r_epc;
    w_misalignHit = 1'b0;
    case (r_state)
      BOOT: w_nextState = RUN;
      TRAP: w_nextState = RUN;
      RUN: begin
        if (exception) begin
          w_nextEpc   = r_pc;
          w_nextPc    = c_excPc;
          w_nextState = TRAP;
        end else if (eret) begin
          w_nextPc = r_epc;
        end else if (pc_write) begin
          // Only the winning target is checked; a misaligned one traps instead of loading.
          if ((jump && w_jumpMis) || (!jump && branch_taken && w_branchMis)) begin
            w_nextEpc     = r_pc;
            w_nextPc      = c_excPc;
            w_nextState   = TRAP;
            w_misalignHit = 1'b1;
          end else if (jump) begin
            w_nextPc = jump_target;
          end else if (branch_taken) begin
            w_nextPc = branch_target;
          end else begin
            w_nextPc = w_pcPlusInc;
          end
        end
      end
      default: w_nextState = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= BOOT;
      r_pc         <= c_resetPc;
      r_epc        <= '0;
      r_fetchValid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_epc        <= w_nextEpc;
      r_fetchValid <= (w_nextState == RUN);
      r_misalign   <= w_misalignHit;
    end
  end

  assign pc          = r_pc;
  assign pc_plus_inc = w_pcPlusInc;
  assign epc         = r_epc;
  assign fetch_valid = r_fetchValid;
  assign misalign    = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
//  Module   : tb_pc_unit
//  Brief    : Directed self-checking bench for pc_unit (32-bit and 8-bit wrap).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite, branchTaken, jumpReq, excReq, eretReq;
  logic [31:0] branchTarget, jumpTarget;
  logic [31:0] pcA, pcPlusIncA, epcA;
  logic        fetchValidA, misalignA;

  logic        rstB;
  logic        pcWriteB;
  logic [7:0]  pcB, pcPlusIncB, epcB;
  logic        fetchValidB, misalignB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit u_dutA (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pcWrite),
    .branch_taken (branchTaken),
    .branch_target(branchTarget),
    .jump         (jumpReq),
    .jump_target  (jumpTarget),
    .exception    (excReq),
    .eret         (eretReq),
    .pc           (pcA),
    .pc_plus_inc  (pcPlusIncA),
    .epc          (epcA),
    .fetch_valid  (fetchValidA),
    .misalign     (misalignA)
  );

  pc_unit #(
    .WIDTH       (8),
    .RESET_VECTOR(32'h0000_00FC)
  ) u_dutB (
    .clk          (clk),
    .rst          (rstB),
    .pc_write     (pcWriteB),
    .branch_taken (1'b0),
    .branch_target(8'h00),
    .jump         (1'b0),
    .jump_target  (8'h00),
    .exception    (1'b0),
    .eret         (1'b0),
    .pc           (pcB),
    .pc_plus_inc  (pcPlusIncB),
    .epc          (epcB),
    .fetch_valid  (fetchValidB),
    .misalign     (misalignB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rstB = 1'b0; pcWriteB = 1'b1;
    pcWrite = 1'b0; branchTaken = 1'b0; jumpReq = 1'b0; excReq = 1'b0; eretReq = 1'b0;
    branchTarget = '0; jumpTarget = '0;

    // 1. Reset and boot
    for (int i = 0; i < 5; i++) step();
    check("rst_pc", pcA, 32'h0);
    check("rst_epc", epcA, 32'h0);
    check("rst_fv", {31'b0, fetchValidA}, 32'd0);
    check("rst_mis", {31'b0, misalignA}, 32'd0);
    rst = 1'b1; pcWrite = 1'b1;
    step();
    check("boot_pc", pcA, 32'h0);
    check("boot_fv", {31'b0, fetchValidA}, 32'd1);
    step(); check("seq_pc4", pcA, 32'h4);
    step(); check("seq_pc8", pcA, 32'h8);
    step(); check("seq_pcC", pcA, 32'hC);
    check("plus_inc", pcPlusIncA, 32'h10);

    // 2. Stall ignores branch
    step(); check("pre_stall", pcA, 32'h10);
    pcWrite = 1'b0; branchTaken = 1'b1; branchTarget = 32'h200;
    step(); check("stall1", pcA, 32'h10);
    step(); check("stall2", pcA, 32'h10);
    pcWrite = 1'b1;
    step(); check("branch", pcA, 32'h200);

    // 3. Jump beats misaligned branch
    jumpReq = 1'b1; jumpTarget = 32'h400; branchTarget = 32'h202;
    step(); check("prio_pc", pcA, 32'h400);
    check("prio_mis", {31'b0, misalignA}, 32'd0);
    branchTaken = 1'b0;

    // 4. Trap and return
    jumpTarget = 32'h24;
    step(); check("jmp24", pcA, 32'h24);
    jumpReq = 1'b0; pcWrite = 1'b0; excReq = 1'b1;
    step();
    check("trap_pc", pcA, 32'h80);
    check("trap_epc", epcA, 32'h24);
    check("trap_fv", {31'b0, fetchValidA}, 32'd0);
    excReq = 1'b0;
    step();
    check("trap_hold", pcA, 32'h80);
    check("trap_fv1", {31'b0, fetchValidA}, 32'd1);
    eretReq = 1'b1;
    step(); check("eret_pc", pcA, 32'h24);
    eretReq = 1'b0;

    // 5. Misaligned branch traps
    pcWrite = 1'b1; jumpReq = 1'b1; jumpTarget = 32'h30;
    step(); check("jmp30", pcA, 32'h30);
    jumpReq = 1'b0; branchTaken = 1'b1; branchTarget = 32'h102;
    step();
    check("mis_pc", pcA, 32'h80);
    check("mis_epc", epcA, 32'h30);
    check("mis_pulse", {31'b0, misalignA}, 32'd1);
    check("mis_fv", {31'b0, fetchValidA}, 32'd0);
    branchTaken = 1'b0;
    step();
    check("mis_hold", pcA, 32'h80);
    check("mis_clear", {31'b0, misalignA}, 32'd0);
    check("mis_fv1", {31'b0, fetchValidA}, 32'd1);
    step(); check("mis_adv", pcA, 32'h84);

    // Reset aborts a trap in progress, epc included
    excReq = 1'b1;
    step();
    excReq = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_pc", pcA, 32'h0);
    check("abort_epc", epcA, 32'h0);
    check("abort_fv", {31'b0, fetchValidA}, 32'd0);

    // 6. 8-bit wrap and asynchronous reset
    rstB = 1'b1;
    step(); check("w8_boot", {24'b0, pcB}, 32'hFC);
    step(); check("w8_wrap", {24'b0, pcB}, 32'h00);
    check("w8_inc", {24'b0, pcPlusIncB}, 32'h04);
    check("w8_fv", {31'b0, fetchValidB}, 32'd1);
    #2 rstB = 1'b0;
    #1;
    check("w8_async_pc", {24'b0, pcB}, 32'hFC);
    check("w8_async_fv", {31'b0, fetchValidB}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
